gtech_or_reduce_pipe: RTL and testbench

//  - Parametrised, pipelined successor to the 2-input generic OR cell.
//  - ORs NUM_IN operands of WIDTH bits each, bitwise, into one WIDTH-bit result.
//  - Uses a RADIX-ary tree with one register slice per tree level.
//  - Valid/ready on both sides, full throughput: one result per cycle when not stalled.
//  - Sits in the generic-tech library.
//  - Used by status/interrupt aggregation and error-flag collection logic.

---
 rtl/gtech_pkg.sv | 36 +++
 rtl/gtech_or_reduce_pipe_if.sv | 27 ++
 rtl/gtech_or_stage.sv | 59 +++++
 rtl/gtech_or_reduce_pipe.sv | 82 ++++++++
 tb/tb_gtech_or_reduce_pipe.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gtech_pkg.sv
// Shared helpers for the generic-tech OR reduction tree: operand/fan-in
// limits and the tree-depth arithmetic used by the top and its stages.
package gtech_pkg;

    localparam int NUM_IN_MAX = 64;
    localparam int RADIX_MAX  = 8;

    // Integer ceiling division, used to size each tree level.
    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Number of tree levels needed to fold n words with fan-in r (at least 1).
    function automatic int clog_radix(input int n, input int r);
        int lv;
        int cnt;
        lv  = 0;
        cnt = n;
        while (cnt > 1) begin
            cnt = ceil_div(cnt, r);
            lv  = lv + 1;
        end
        return (lv < 1) ? 1 : lv;
    endfunction

    // Word count present after k levels of folding n words with fan-in r.
    function automatic int level_count(input int n, input int r, input int k);
        int cnt;
        cnt = n;
        for (int i = 0; i < k; i++) begin
            cnt = ceil_div(cnt, r);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gtech_or_reduce_pipe_if.sv
// Valid/ready bus of the pipelined OR reduction. The STICKY_CLR/STICKY pair
// only exists when GTECH_OR_STICKY_EN is defined.
interface gtech_or_reduce_pipe_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 8
);
    logic                    IN_VALID;
    logic                    IN_READY;
    logic [NUM_IN*WIDTH-1:0] A;
    logic                    Z_VALID;
    logic                    Z_READY;
    logic [WIDTH-1:0]        Z;
`ifdef GTECH_OR_STICKY_EN
    logic                    STICKY_CLR;
    logic [WIDTH-1:0]        STICKY;

    modport master (output IN_VALID, A, Z_READY, STICKY_CLR,
                    input  IN_READY, Z_VALID, Z, STICKY);
    modport slave  (input  IN_VALID, A, Z_READY, STICKY_CLR,
                    output IN_READY, Z_VALID, Z, STICKY);
`else
    modport master (output IN_VALID, A, Z_READY,
                    input  IN_READY, Z_VALID, Z);
    modport slave  (input  IN_VALID, A, Z_READY,
                    output IN_READY, Z_VALID, Z);
`endif
endinterface

// File: rtl/gtech_or_stage.sv
// One level of the OR tree: folds groups of RADIX words (short last group
// padded with zero) and registers the result with its valid bit. An empty
// slot always accepts, so bubbles collapse under backpressure.
module gtech_or_stage
    import gtech_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_IN  = 8,
    parameter  int RADIX = 2,
    localparam int N_OUT = ceil_div(N_IN, RADIX)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [N_IN*WIDTH-1:0]  i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [N_OUT*WIDTH-1:0] o_data
);

    localparam int PAD_W = N_OUT * RADIX * WIDTH;

    logic [PAD_W-1:0]       w_pad;
    logic [N_OUT*WIDTH-1:0] w_or;
    logic                   r_valid;
    logic [N_OUT*WIDTH-1:0] r_data;

    // Zero-extend so the last group can always read RADIX full words.
    assign w_pad   = PAD_W'(i_data);
    assign o_ready = !r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // OR each group of RADIX words into one output word.
    always_comb begin
        w_or = '0;
        for (int g = 0; g < N_OUT; g++) begin
            for (int j = 0; j < RADIX; j++) begin
                w_or[g*WIDTH +: WIDTH] = w_or[g*WIDTH +: WIDTH]
                                       | w_pad[(g*RADIX + j)*WIDTH +: WIDTH];
            end
        end
    end

    // Register slice: load when downstream has room, keep data when idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_or;
            end
        end
    end

endmodule

// File: rtl/gtech_or_reduce_pipe.sv
// Pipelined bitwise OR of NUM_IN operands of WIDTH bits through a RADIX-ary
// tree, one register slice per level, full throughput with valid/ready.
// Optional feature macro: GTECH_OR_STICKY_EN adds an accumulator (STICKY)
// of every delivered result, cleared by STICKY_CLR.
module gtech_or_reduce_pipe
    import gtech_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 8,
    parameter int RADIX  = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    gtech_or_reduce_pipe_if.slave bus
);

    localparam int LEVELS = clog_radix(NUM_IN, RADIX);

    // w_vld[k] is the valid out of level k (0 = input); w_rdy[k] is the
    // ready into level k, with LEVELS+1 being the downstream ready.
    logic [LEVELS:0]   w_vld;
    logic [LEVELS+1:1] w_rdy;
    logic [WIDTH-1:0]  w_z;

    assign w_vld[0]        = bus.IN_VALID;
    assign w_rdy[LEVELS+1] = bus.Z_READY;
    assign bus.IN_READY    = w_rdy[1];
    assign bus.Z_VALID     = w_vld[LEVELS];
    assign bus.Z           = w_z;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int N_I = level_count(NUM_IN, RADIX, k - 1);
        localparam int N_O = level_count(NUM_IN, RADIX, k);

        logic [N_I*WIDTH-1:0] w_in;
        logic [N_O*WIDTH-1:0] w_q;

        if (k == 1) begin : g_src
            assign w_in = bus.A;
        end else begin : g_src
            assign w_in = g_lvl[k-1].w_q;
        end

        gtech_or_stage #(
            .WIDTH (WIDTH),
            .N_IN  (N_I),
            .RADIX (RADIX)
        ) u_stage (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_valid (w_vld[k-1]),
            .o_ready (w_rdy[k]),
            .i_data  (w_in),
            .o_valid (w_vld[k]),
            .i_ready (w_rdy[k+1]),
            .o_data  (w_q)
        );
    end

    // The last level always folds down to a single word.
    assign w_z = g_lvl[LEVELS].w_q;

`ifdef GTECH_OR_STICKY_EN
    logic             w_hs;
    logic [WIDTH-1:0] r_sticky;

    assign w_hs       = w_vld[LEVELS] & bus.Z_READY;
    assign bus.STICKY = r_sticky;

    // Accumulate delivered results; a clear in the same cycle wins first.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sticky <= '0;
        end else if (bus.STICKY_CLR) begin
            r_sticky <= w_hs ? w_z : '0;
        end else if (w_hs) begin
            r_sticky <= r_sticky | w_z;
        end
    end
`endif

endmodule

// File: tb/tb_gtech_or_reduce_pipe.sv
// Scoreboard bench for gtech_or_reduce_pipe: main instance 8x8 radix 2 and
// a 5-operand radix-3 instance. Sticky checks build with GTECH_OR_STICKY_EN.
`timescale 1ns/1ps
module tb_gtech_or_reduce_pipe;

    localparam int W   = 8;
    localparam int N   = 8;
    localparam int R   = 2;
    localparam int LV  = 3;
    localparam int N5  = 5;
    localparam int R5  = 3;
    localparam int LV5 = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    gtech_or_reduce_pipe_if #(.WIDTH(W), .NUM_IN(N))  bus  ();
    gtech_or_reduce_pipe_if #(.WIDTH(W), .NUM_IN(N5)) bus5 ();

    gtech_or_reduce_pipe #(.WIDTH(W), .NUM_IN(N),  .RADIX(R))  dut  (.CLK(CLK), .RST(RST), .bus(bus));
    gtech_or_reduce_pipe #(.WIDTH(W), .NUM_IN(N5), .RADIX(R5)) dut5 (.CLK(CLK), .RST(RST), .bus(bus5));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int zcount = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   prev_z;
    bit             prev_stall = 0;
    logic [N*W-1:0]  a;
    logic [N*W-1:0]  tmp;
    logic [N5*W-1:0] a5;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: a result is simply the bitwise OR of the first n operands.
    function automatic logic [W-1:0] ref_or(input logic [N*W-1:0] v, input int n);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = r | v[i*W +: W];
        return r;
    endfunction

    function automatic logic [N*W-1:0] rand_a();
        logic [N*W-1:0] r;
        for (int j = 0; j < N; j++)
            r[j*W +: W] = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
        return r;
    endfunction

    always @(posedge CLK) cyc++;

    // Monitor: pop-and-compare on every Z handshake, push on every accept.
    always @(negedge CLK) begin
        if (RST) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("z_hold_valid", 32'(bus.Z_VALID), 32'd1);
                chk("z_hold_data", 32'(bus.Z), 32'(prev_z));
            end
            if (bus.Z_VALID && bus.Z_READY) begin
                zcount++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL z_unexpected: got 0x%0h with empty scoreboard", bus.Z);
                end else begin
                    chk("z_data", 32'(bus.Z), 32'(exp_q.pop_front()));
                end
            end
            if (bus.IN_VALID && bus.IN_READY) exp_q.push_back(ref_or(bus.A, N));
            prev_stall = bus.Z_VALID && !bus.Z_READY;
            prev_z     = bus.Z;
        end
    end

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [N*W-1:0] v);
        int t;
        t = 0;
        bus.IN_VALID = 1'b1;
        bus.A        = v;
        @(negedge CLK);
        while (!bus.IN_READY && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (!bus.IN_READY) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic wait_z(output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!bus.Z_VALID && lat < 20);
    endtask

    task automatic odd_txn(input logic [N5*W-1:0] v, output int lat);
        bus5.IN_VALID = 1'b1;
        bus5.A        = v;
        @(negedge CLK);
        @(posedge CLK); #1;
        bus5.IN_VALID = 1'b0;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!bus5.Z_VALID && lat < 20);
    endtask

`ifdef GTECH_OR_STICKY_EN
    task automatic deliver(input logic [W-1:0] op0, input bit clr);
        int lat;
        logic [N*W-1:0] v;
        v = '0;
        v[W-1:0] = op0;
        send(v);
        while (!bus.Z_VALID && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        wait_z(lat);
        if (clr) bus.STICKY_CLR = 1'b1;
        @(posedge CLK); #1;
        bus.STICKY_CLR = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, acc, run, start, z0, stale;
        bit hs_last;
        bus.IN_VALID  = 1'b0;  bus.A  = '0; bus.Z_READY  = 1'b1;
        bus5.IN_VALID = 1'b0;  bus5.A = '0; bus5.Z_READY = 1'b1;
`ifdef GTECH_OR_STICKY_EN
        bus.STICKY_CLR  = 1'b0;
        bus5.STICKY_CLR = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        chk("rst_z_valid", 32'(bus.Z_VALID), 32'd0);
        chk("rst_z", 32'(bus.Z), 32'd0);
        chk("rst_in_ready", 32'(bus.IN_READY), 32'd1);
        chk("rst_in_ready_odd", 32'(bus5.IN_READY), 32'd1);
`ifdef GTECH_OR_STICKY_EN
        chk("rst_sticky", 32'(bus.STICKY), 32'd0);
`endif
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_in_ready", 32'(bus.IN_READY), 32'd1);
        @(posedge CLK); #1;

        // Basic: single operand 0x01, latency LV.
        a = '0;
        a[3*W +: W] = 8'h01;
        send(a);
        wait_z(lat);
        chk("basic_latency", 32'(lat), 32'(LV));
        chk("basic_z", 32'(bus.Z), 32'h01);
        @(posedge CLK); #1;

        // Streaming: back-to-back, every result 0xFF, one per cycle.
        start = cyc;
        run   = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    for (int j = 0; j < N; j++) a[j*W +: W] = 8'h01 << ((i + j) % 8);
                    send(a);
                end
                chk("stream_cycles", 32'(cyc - start), 32'd16);
            end
            begin
                wait_z(lat);
                for (int k = 0; k < 16; k++) begin
                    if (bus.Z_VALID && bus.Z == 8'hFF) run++;
                    if (k < 15) @(negedge CLK);
                end
                chk("stream_run", 32'(run), 32'd16);
            end
        join
        repeat (5) @(posedge CLK); #1;

        // Backpressure: Z_READY low for 5 cycles with IN_VALID high.
        bus.Z_READY  = 1'b0;
        bus.IN_VALID = 1'b1;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            a = '0;
            a[W-1:0] = 8'h01 << acc;
            bus.A = a;
            @(negedge CLK);
            if (bus.IN_READY) acc++;
            @(posedge CLK); #1;
        end
        chk("bp_accepts", 32'(acc), 32'd3);
        @(negedge CLK);
        chk("bp_in_ready_low", 32'(bus.IN_READY), 32'd0);
        @(posedge CLK); #1;
        z0 = zcount;
        bus.IN_VALID = 1'b0;
        bus.Z_READY  = 1'b1;
        repeat (6) @(posedge CLK); #1;
        chk("bp_outputs", 32'(zcount - z0), 32'd3);

        // Odd configuration: NUM_IN=5, RADIX=3.
        a5 = '0;
        a5[4*W +: W] = 8'h80;
        odd_txn(a5, lat);
        chk("odd_latency", 32'(lat), 32'(LV5));
        chk("odd_z", 32'(bus5.Z), 32'h80);
        repeat (3) @(negedge CLK);
        chk("odd_idle_valid", 32'(bus5.Z_VALID), 32'd0);
        chk("odd_idle_hold", 32'(bus5.Z), 32'h80);
        @(posedge CLK); #1;
        for (int i = 0; i < 10; i++) begin
            tmp = rand_a();
            a5  = tmp[N5*W-1:0];
            odd_txn(a5, lat);
            chk("odd_rand_latency", 32'(lat), 32'(LV5));
            chk("odd_rand_z", 32'(bus5.Z), 32'(ref_or(N'(0) == 0 ? {{((N-N5)*W){1'b0}}, a5} : '0, N5)));
            @(posedge CLK); #1;
        end

        // Reset with two results in flight.
        a = '0; a[W-1:0] = 8'h21; send(a);
        a = '0; a[W-1:0] = 8'h42; send(a);
        #1;
        RST = 1'b1;
        #1;
        chk("midrst_z_valid", 32'(bus.Z_VALID), 32'd0);
        chk("midrst_z", 32'(bus.Z), 32'd0);
        chk("midrst_in_ready", 32'(bus.IN_READY), 32'd1);
`ifdef GTECH_OR_STICKY_EN
        chk("midrst_sticky", 32'(bus.STICKY), 32'd0);
`endif
        exp_q.delete();
        repeat (2) @(posedge CLK); #1;
        RST = 1'b0;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (bus.Z_VALID) stale++;
        end
        chk("midrst_no_stale", 32'(stale), 32'd0);
        @(posedge CLK); #1;

`ifdef GTECH_OR_STICKY_EN
        // Sticky accumulation and clear-with-handshake.
        deliver(8'h01, 1'b0);
        deliver(8'h10, 1'b0);
        @(negedge CLK);
        chk("sticky_acc", 32'(bus.STICKY), 32'h11);
        @(posedge CLK); #1;
        deliver(8'h04, 1'b1);
        @(negedge CLK);
        chk("sticky_clr_hs", 32'(bus.STICKY), 32'h04);
        @(posedge CLK); #1;
        bus.STICKY_CLR = 1'b1;
        @(posedge CLK); #1;
        bus.STICKY_CLR = 1'b0;
        @(negedge CLK);
        chk("sticky_clr_only", 32'(bus.STICKY), 32'h00);
        @(posedge CLK); #1;
`endif

        // Randomized traffic with random backpressure.
        hs_last = 0;
        bus.IN_VALID = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!bus.IN_VALID || hs_last) begin
                bus.IN_VALID = $urandom_range(0, 1) == 1;
                bus.A        = rand_a();
            end
            bus.Z_READY = $urandom_range(0, 3) != 0;
            @(negedge CLK);
            hs_last = bus.IN_VALID && bus.IN_READY;
            @(posedge CLK); #1;
        end
        bus.IN_VALID = 1'b0;
        bus.Z_READY  = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge CLK);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
